// File: rtl/imem_loader_if.sv
// Load-stream and fetch bus shared by the program source/CPU side and imem_loader.
// Latency: none (signal bundle only).
// Backpressure: ld_ready from the slave throttles ld_valid/ld_data/ld_last from the master.
interface imem_loader_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 16
);
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic [PC_W-1:0]   lc;
  logic [DATA_W-1:0] instr_load;

  modport master (
    output ld_valid, ld_data, ld_last, lc,
    input  ld_ready, instr_load
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, lc,
    output ld_ready, instr_load
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory with streamed program loader and one-shot CPU start pulse.
// Latency: fetch is combinational (1 cycle when IMEM_REG_OUT_EN is defined); start_flag START_DLY+1 cycles after last word.
// Backpressure: ld_ready is high only while idle/loading; once the image is complete further words are refused until reload/rst.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int PC_W      = 16,
  parameter int START_DLY = 4
) (
  input  logic              clk,
  input  logic              rst,
  imem_loader_if.slave      bus,
  input  logic              reload,
  output logic              start_flag,
  output logic              loaded,
  output logic [ADDR_W:0]   load_count,
  output logic              fetch_err
);

  localparam logic [DATA_W-1:0] NOP      = DATA_W'(32'h0000_0013);
  localparam logic [ADDR_W:0]   LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [7:0]        DLY      = 8'(START_DLY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DELAY,
    S_START,
    S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        dly_q, dly_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic              wr_en;
  logic              img_done;
  logic              fetch_ok;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] rd_dat;

  assign bus.ld_ready = (state_q == S_IDLE) || (state_q == S_LOAD);

  // reload (and rst) win over a same-cycle transfer: that word is dropped
  assign wr_en    = bus.ld_valid && bus.ld_ready && !reload && !rst;
  // filling the last word is an implicit end of image
  assign img_done = bus.ld_last || (cnt_q == LAST_IDX);

  assign idx      = bus.lc[ADDR_W+1:2];
  // load_count bound hides stale words left over from earlier images
  assign fetch_ok = (state_q == S_RUN) &&
                    (bus.lc[1:0] == 2'b00) &&
                    (bus.lc[PC_W-1:ADDR_W+2] == '0) &&
                    ({1'b0, idx} < cnt_q);
  assign rd_dat   = fetch_ok ? mem[idx] : NOP;

  assign start_flag = (state_q == S_START);
  assign loaded     = (state_q == S_RUN);
  assign load_count = cnt_q;
  assign fetch_err  = err_q;

  // Next state: load sequencing, start delay countdown, sticky fetch error
  always_comb begin
    state_d = state_q;
    dly_d   = '0;
    cnt_d   = cnt_q;
    err_d   = err_q;

    if (wr_en) begin
      cnt_d = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
    end
    if ((state_q == S_RUN) && !fetch_ok) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (wr_en) begin
          if (img_done) begin
            state_d = (START_DLY == 0) ? S_START : S_DELAY;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      // DELAY is entered with dly_q=0 and left when it reaches START_DLY, so
      // the pulse lands START_DLY+1 edges after the last accepted word
      S_DELAY: begin
        if (dly_q == DLY) begin
          state_d = S_START;
        end else begin
          dly_d = dly_q + 8'd1;
        end
      end
      S_START: state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    if (reload) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      err_d   = 1'b0;
      dly_d   = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dly_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Program store; contents survive rst/reload by design
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[cnt_q[ADDR_W-1:0]] <= bus.ld_data;
    end
  end

`ifdef IMEM_REG_OUT_EN
  logic [DATA_W-1:0] instr_q;

  // Registered read: validity judged on the lc sampled at this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP;
    end else begin
      instr_q <= rd_dat;
    end
  end

  assign bus.instr_load = instr_q;
`else
  assign bus.instr_load = rd_dat;
`endif

endmodule
